// File: rtl/calc_div_pkg.sv
// Shared definitions for the calculator's 4-bit signed divide sequencer:
// state encoding, operand corner values and complement-unit tie-offs.
package calc_div_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ABS_A  = 3'd1;
  localparam logic [2:0] ST_WAIT_A = 3'd2;
  localparam logic [2:0] ST_ABS_B  = 3'd3;
  localparam logic [2:0] ST_WAIT_B = 3'd4;
  localparam logic [2:0] ST_DIV    = 3'd5;
  localparam logic [2:0] ST_SIGN   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ABS_A  = ST_ABS_A,
    WAIT_A = ST_WAIT_A,
    ABS_B  = ST_ABS_B,
    WAIT_B = ST_WAIT_B,
    DIV    = ST_DIV,
    SIGN   = ST_SIGN,
    DONE   = ST_DONE
  } div_state_e;

  localparam logic [3:0] MIN_NEG       = 4'b1000;
  localparam int         DIV_STEPS     = 4;
  localparam logic [3:0] COMP_B_CONST  = 4'd0;
  localparam logic       COMP_CI_CONST = 1'b1;

  // Two's complement negation; zero maps back to zero.
  function automatic logic [3:0] negate4(input logic [3:0] v);
    return (~v) + 4'd1;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor magnitude if it fits.
module div_restore_step (
  input  logic [4:0] r_in,
  input  logic       bit_in,
  input  logic [4:0] mag_b,
  output logic [4:0] r_out,
  output logic       q_bit
);

  logic [4:0] shifted;

  assign shifted = {r_in[3:0], bit_in};

  always_comb begin
    r_out = shifted;
    q_bit = 1'b0;
    if (shifted >= mag_b) begin
      r_out = shifted - mag_b;
      q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/division_ctrl_4bits.sv
// Sequencer for the calculator's 4-bit signed divide: magnitudes via the
// shared complement unit, 4-step restoring divide, then sign fix-up.
module division_ctrl_4bits
  import calc_div_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int COMP_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             comp_sel,
  output logic [WIDTH-1:0] comp_a,
  output logic [WIDTH-1:0] comp_b,
  output logic             comp_ci,
  input  logic [WIDTH-1:0] comp_sum,
  input  logic             comp_finish
);

  div_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       comp_sel_q, comp_sel_d;
  logic [3:0] comp_a_q, comp_a_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] mag_a_q, mag_a_d;
  logic [3:0] mag_b_q, mag_b_d;
  logic [4:0] r_q, r_d;
  logic [3:0] q_acc_q, q_acc_d;
  logic [1:0] step_q, step_d;
  logic [1:0] wait_q, wait_d;

  logic [4:0] step_r;
  logic       step_q_bit;
  logic       bad_operands;

  div_restore_step u_step (
    .r_in   (r_q),
    .bit_in (mag_a_q[step_q]),
    .mag_b  ({1'b0, mag_b_q}),
    .r_out  (step_r),
    .q_bit  (step_q_bit)
  );

  // -8 has no 4-bit magnitude, so it is rejected up front along with /0.
  assign bad_operands = (divisor == 4'd0) || (dividend == MIN_NEG) ||
                        (divisor == MIN_NEG);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    comp_sel_d = 1'b0;
    comp_a_d   = comp_a_q;
    a_d        = a_q;
    b_d        = b_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    r_d        = r_q;
    q_acc_d    = q_acc_q;
    step_d     = step_q;
    wait_d     = wait_q;

    case (state_q)
      IDLE: begin
        // done_q high means this is the done cycle, where start is ignored.
        if (start && !done_q) begin
          a_d    = dividend;
          b_d    = divisor;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (bad_operands) begin
            err_d   = 1'b1;
            quot_d  = 4'd0;
            rem_d   = 4'd0;
            state_d = DONE;
          end else begin
            comp_sel_d = 1'b1;
            comp_a_d   = dividend;
            state_d    = ABS_A;
          end
        end
      end

      ABS_A: begin
        wait_d  = 2'(COMP_LATENCY - 1);
        state_d = WAIT_A;
      end

      WAIT_A: begin
        if (wait_q != 2'd0) begin
          wait_d = wait_q - 2'd1;
        end else if (!comp_finish) begin
          err_d   = 1'b1;
          quot_d  = 4'd0;
          rem_d   = 4'd0;
          state_d = DONE;
        end else begin
          mag_a_d    = comp_sum;
          comp_sel_d = 1'b1;
          comp_a_d   = b_q;
          state_d    = ABS_B;
        end
      end

      ABS_B: begin
        wait_d  = 2'(COMP_LATENCY - 1);
        state_d = WAIT_B;
      end

      WAIT_B: begin
        if (wait_q != 2'd0) begin
          wait_d = wait_q - 2'd1;
        end else if (!comp_finish) begin
          err_d   = 1'b1;
          quot_d  = 4'd0;
          rem_d   = 4'd0;
          state_d = DONE;
        end else begin
          mag_b_d = comp_sum;
          r_d     = 5'd0;
          q_acc_d = 4'd0;
          step_d  = 2'(DIV_STEPS - 1);
          state_d = DIV;
        end
      end

      DIV: begin
        r_d             = step_r;
        q_acc_d[step_q] = step_q_bit;
        if (step_q == 2'd0) begin
          state_d = SIGN;
        end else begin
          step_d = step_q - 2'd1;
        end
      end

      SIGN: begin
        // Truncating division: remainder follows the dividend's sign.
        quot_d  = (a_q[3] ^ b_q[3]) ? negate4(q_acc_q) : q_acc_q;
        rem_d   = a_q[3] ? negate4(r_q[3:0]) : r_q[3:0];
        state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      quot_q     <= 4'd0;
      rem_q      <= 4'd0;
      comp_sel_q <= 1'b0;
      comp_a_q   <= 4'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      mag_a_q    <= 4'd0;
      mag_b_q    <= 4'd0;
      r_q        <= 5'd0;
      q_acc_q    <= 4'd0;
      step_q     <= 2'd0;
      wait_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      comp_sel_q <= comp_sel_d;
      comp_a_q   <= comp_a_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      r_q        <= r_d;
      q_acc_q    <= q_acc_d;
      step_q     <= step_d;
      wait_q     <= wait_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign comp_sel  = comp_sel_q;
  assign comp_a    = comp_a_q;
  assign comp_b    = COMP_B_CONST;
  assign comp_ci   = COMP_CI_CONST;

endmodule

// File: tb/tb_division_ctrl_4bits.sv
// Bench for division_ctrl_4bits: two instances (complement latency 1 and 2)
// with behavioural complement units and a queue of expected results.
module tb_division_ctrl_4bits;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
    bit         chk_qr;
    int         lat;
    int         sels;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic [3:0] dividend, divisor;
  logic       busy1, done1, err1, comp_sel1, comp_ci1, comp_finish1;
  logic [3:0] quot1, rem1, comp_a1, comp_b1, comp_sum1;
  logic       busy2, done2, err2, comp_sel2, comp_ci2, comp_finish2;
  logic [3:0] quot2, rem2, comp_a2, comp_b2, comp_sum2;
  logic [3:0] pipe2;

  int checks = 0;
  int errors = 0;
  int sel_cnt1 = 0;
  int sel_cnt2 = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  division_ctrl_4bits #(.WIDTH(4), .COMP_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .dividend(dividend), .divisor(divisor),
    .busy(busy1), .done(done1), .err(err1), .quotient(quot1), .remainder(rem1),
    .comp_sel(comp_sel1), .comp_a(comp_a1), .comp_b(comp_b1), .comp_ci(comp_ci1),
    .comp_sum(comp_sum1), .comp_finish(comp_finish1)
  );

  division_ctrl_4bits #(.WIDTH(4), .COMP_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dividend(dividend), .divisor(divisor),
    .busy(busy2), .done(done2), .err(err2), .quotient(quot2), .remainder(rem2),
    .comp_sel(comp_sel2), .comp_a(comp_a2), .comp_b(comp_b2), .comp_ci(comp_ci2),
    .comp_sum(comp_sum2), .comp_finish(comp_finish2)
  );

  function automatic logic [3:0] mag4(input logic [3:0] v);
    return v[3] ? 4'((~v) + 4'd1) : v;
  endfunction

  // Complement unit, one-cycle latency.
  always @(posedge clk or posedge rst) begin
    if (rst) comp_sum1 <= 4'd0;
    else if (comp_sel1) comp_sum1 <= mag4(comp_a1);
  end

  // Complement unit, two-cycle latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe2     <= 4'd0;
      comp_sum2 <= 4'd0;
    end else begin
      if (comp_sel2) pipe2 <= mag4(comp_a2);
      comp_sum2 <= pipe2;
    end
  end

  always @(posedge clk) begin
    if (comp_sel1) sel_cnt1 <= sel_cnt1 + 1;
    if (comp_sel2) sel_cnt2 <= sel_cnt2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input int lat_l);
    exp_t e;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    e.chk_qr = 1'b1;
    if (b == 4'd0 || a == 4'b1000 || b == 4'b1000) begin
      e.q = 4'd0; e.r = 4'd0; e.err = 1'b1; e.lat = 1; e.sels = 0;
    end else begin
      e.q = 4'(sa / sb); e.r = 4'(sa % sb); e.err = 1'b0;
      e.lat = 8 + 2 * lat_l; e.sels = 2;
    end
    return e;
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit use2,
                        input bit poke, input exp_t e);
    exp_t got;
    int lat, sel0;
    bit seen;
    logic [3:0] hold_q, hold_r;
    sb_q.push_back(e);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    if (use2) start2 = 1'b1; else start1 = 1'b1;
    sel0 = use2 ? sel_cnt2 : sel_cnt1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    check("busy_after_start", use2 ? busy2 : busy1, 1);
    check("comp_b_tie", use2 ? comp_b2 : comp_b1, 0);
    check("comp_ci_tie", use2 ? comp_ci2 : comp_ci1, 1);
    if (e.lat > 1) check("comp_a_dividend", use2 ? comp_a2 : comp_a1, a);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (poke && k == 6) begin
        dividend = 4'd1; divisor = 4'd1; start1 = 1'b1;
      end else if (poke && k == 7) begin
        start1 = 1'b0; dividend = a; divisor = b;
      end
      if (use2 ? done2 : done1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("done_seen", seen, 1);
    got = sb_q.pop_front();
    check("latency", lat, got.lat);
    check("busy_at_done", use2 ? busy2 : busy1, 0);
    check("err", use2 ? err2 : err1, got.err);
    if (got.chk_qr) begin
      check("quotient", use2 ? quot2 : quot1, got.q);
      check("remainder", use2 ? rem2 : rem1, got.r);
    end
    check("sel_pulses", (use2 ? sel_cnt2 : sel_cnt1) - sel0, got.sels);
    if (poke) begin
      hold_q = quot1;
      hold_r = rem1;
      dividend = 4'd1; divisor = 4'd1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      check("poke_busy", busy1, 0);
      check("poke_quotient", quot1, got.q);
      check("poke_remainder", rem1, got.r);
      check("poke_held_q", quot1, hold_q);
      check("poke_held_r", rem1, hold_r);
    end
  endtask

  task automatic applyStimulus();
    exp_t e;
    bit saw_done;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    dividend = 4'd0; divisor = 4'd0;
    comp_finish1 = 1'b1; comp_finish2 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_err", err1, 0);
    check("rst_quotient", quot1, 0);
    check("rst_remainder", rem1, 0);
    check("rst_comp_sel", comp_sel1, 0);
    check("rst_comp_a", comp_a1, 0);

    run_op(4'd7, 4'd2, 1'b0, 1'b0, model(4'd7, 4'd2, 1));
    run_op(4'b1001, 4'd2, 1'b0, 1'b0, model(4'b1001, 4'd2, 1));
    run_op(4'd6, 4'b1101, 1'b0, 1'b0, model(4'd6, 4'b1101, 1));
    run_op(4'd5, 4'd0, 1'b0, 1'b0, model(4'd5, 4'd0, 1));
    run_op(4'b1000, 4'd3, 1'b0, 1'b0, model(4'b1000, 4'd3, 1));
    run_op(4'd6, 4'd4, 1'b0, 1'b1, model(4'd6, 4'd4, 1));
    run_op(4'd3, 4'b1110, 1'b0, 1'b0, model(4'd3, 4'b1110, 1));

    // Asynchronous reset while dividing.
    @(negedge clk);
    dividend = 4'd7; divisor = 4'd2; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_busy", busy1, 0);
    check("async_done", done1, 0);
    check("async_quotient", quot1, 0);
    check("async_remainder", rem1, 0);
    check("async_comp_a", comp_a1, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done1) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op(4'd3, 4'd3, 1'b0, 1'b0, model(4'd3, 4'd3, 1));

    // Complement unit reporting no finish.
    comp_finish1 = 1'b0;
    e = '{q: 4'd0, r: 4'd0, err: 1'b1, chk_qr: 1'b0, lat: 3, sels: 1};
    run_op(4'd7, 4'd2, 1'b0, 1'b0, e);
    comp_finish1 = 1'b1;

    run_op(4'd7, 4'd2, 1'b1, 1'b0, model(4'd7, 4'd2, 2));
  endtask

  task automatic checkOutput();
    check("scoreboard_empty", sb_q.size(), 0);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/division_ctrl_4bits.md
Name: division_ctrl_4bits

Overview:
- Sequencer for a 4-bit signed divide in the calculator datapath.
- Uses the shared one-cycle complement unit (sel/finish interface) to take the magnitude of each operand.
- Runs a 4-step restoring division on the magnitudes, then applies the result signs itself.
- Presents a start/busy/done handshake to the calculator top-level FSM.

Parameters:
- WIDTH, 4: operand width. Only 4 is supported.
- COMP_LATENCY, 1: cycles from comp_sel high to comp_sum valid. Range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request, sampled only in IDLE
- dividend  in  4  two's complement, captured when start is accepted
- divisor  in  4  two's complement, captured when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; results valid from this cycle on
- err  out  1  valid with done, held until the next start
- quotient  out  4  two's complement, held until the next start
- remainder  out  4  two's complement, held until the next start
- comp_sel  out  1  one-cycle request to the complement unit
- comp_a  out  4  operand to the complement unit
- comp_b  out  4  tied to 4'd0
- comp_ci  out  1  tied to 1'b1, so the unit returns the magnitude
- comp_sum  in  4  registered magnitude from the complement unit
- comp_finish  in  1  unit finish flag, sticky in the unit

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, err, comp_sel = 0; quotient, remainder, comp_a = 0; internal registers cleared.
- Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, ABS_A, WAIT_A, ABS_B, WAIT_B, DIV, SIGN, DONE.
- IDLE
  - On start=1: capture dividend and divisor; clear err.
  - If divisor==0, or dividend==4'b1000, or divisor==4'b1000: set err=1, quotient=0, remainder=0, go to DONE.
  - Otherwise go to ABS_A.
  - start while busy or in DONE is ignored.
- ABS_A: comp_sel=1, comp_a=dividend register, for one cycle. Go to WAIT_A.
- WAIT_A
  - Stay COMP_LATENCY cycles; then latch comp_sum as mag_a.
  - If comp_finish=0 at the sample point: set err and go to DONE.
- ABS_B / WAIT_B: same as ABS_A / WAIT_A for the divisor, producing mag_b.
- comp_sel is asserted exactly twice per non-error operation, every time, including for non-negative operands. Latency is fixed.
- DIV: four cycles, counter 3 down to 0, 5-bit partial remainder r, starting r=0.
  - Each cycle: r = {r[3:0], mag_a[i]}.
  - If r >= mag_b: r = r - mag_b and q[i]=1; else q[i]=0.
- SIGN
  - Quotient is negated (two's complement) if the operand sign bits differ.
  - Remainder takes the dividend's sign (truncation toward zero), so a negative dividend negates r[3:0].
  - A zero result stays 0.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start in this cycle is ignored.
- Latency with COMP_LATENCY=1: start accepted at edge 0; done high in the cycle following edge 10. Error-path done follows edge 1.
- Width: all internal arithmetic is 5-bit unsigned. Results fit in 4 bits because |q| ≤ 7 and |r| ≤ 6.

Decomposition:
- Shared package calc_div_pkg holds:
  - state encoding (3-bit localparams)
  - MIN_NEG = 4'b1000
  - DIV_STEPS = 4
  - COMP_B_CONST = 4'd0 and COMP_CI_CONST = 1'b1
- One natural sub-module, div_restore_step: the combinational single restoring step, taking r_in, bit_in and mag_b and returning r_out and q_bit. It is instanced once and iterated by the FSM.
- The complement unit stays external and is connected at the calculator top level.

Test Plan:
- 7 / 2 → quotient=4'b0011, remainder=4'b0001, err=0, done in the cycle after edge 10, comp_sel pulses exactly twice with comp_b=0 and comp_ci=1.
- -7 (4'b1001) / 2 → quotient=4'b1101 (-3), remainder=4'b1111 (-1); 6 / -3 (4'b1101) → quotient=4'b1110, remainder=0.
- 5 / 0 → err=1, quotient=0, remainder=0, done in the cycle after edge 1, no comp_sel pulse; -8 / 3 → same error response.
- Start pulsed again in the DIV state and during done → ignored, results of the first operation unchanged; a later start in IDLE runs normally.
- Assert rst during DIV → all outputs 0 immediately (asynchronous), no done; after release, 3 / 3 gives quotient=1, remainder=0.
- Hold comp_finish=0 during WAIT_A → err=1, done in the cycle after edge 3; repeat 7 / 2 with COMP_LATENCY=2 → done in the cycle after edge 12.
